// File: rtl/i2s_pkg.sv
// Shared constants for the i2s_rx / i2s_tx / i2s_master_tx family:
// default sample width, frame-counter layout and slot-index helpers.
package i2s_pkg;
    localparam int I2S_BITSIZE_DEF = 16;
    localparam int I2S_CNT_W       = 8;
    localparam int I2S_BCLK_BIT    = 1;
    localparam int I2S_SLOT_LSB    = 2;
    localparam int I2S_SLOT_MSB    = 6;
    localparam int I2S_LR_BIT      = 7;
    localparam int I2S_SLOT_W      = I2S_SLOT_MSB - I2S_SLOT_LSB + 1;
    localparam logic [I2S_CNT_W-1:0] I2S_CNT_LAST = '1;

    // Data slots are 1..bitsize; slot 0 is the one-BCLK delay after DACLRC flips.
    function automatic logic slot_has_data(input logic [I2S_SLOT_W-1:0] slot, input int bitsize);
        return (slot != '0) && (int'(slot) <= bitsize);
    endfunction
endpackage

// File: rtl/i2s_frame_fifo.sv
// Stereo-frame FIFO; pointers carry one extra wrap bit to separate full from empty.
module i2s_frame_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wp, r_rp;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push, w_do_pop;

    assign o_empty   = (r_wp == r_rp);
    assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rp <= r_rp + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_wdata;
    end
endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: OSC/4 bit clock, 64-BCLK frames, frame FIFO in front.
// Optional macro I2S_UNDERRUN_CNT_EN adds a saturating 16-bit underrun_count output.
module i2s_master_tx
    import i2s_pkg::*;
#(
    parameter int BITSIZE    = I2S_BITSIZE_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               OSC,
    input  logic               RESET,
    input  logic [BITSIZE-1:0] left_chan,
    input  logic [BITSIZE-1:0] right_chan,
    input  logic               valid,
    output logic               ready,
    output logic               MCLK,
    output logic               BCLK,
    output logic               DACLRC,
    output logic               DACDAT,
    output logic               underrun
`ifdef I2S_UNDERRUN_CNT_EN
    ,
    output logic [15:0]        underrun_count
`endif
);
    localparam int FW = 2 * BITSIZE;

    logic [I2S_CNT_W-1:0]  r_cnt;
    logic [I2S_SLOT_W-1:0] w_slot;
    logic                  w_wrap, w_bclk_fall, w_data_slot;
    logic                  w_push, w_full, w_empty;
    logic                  r_rdy_en, r_dacdat, r_underrun;
    logic [FW-1:0]         w_fifo_q, r_shreg;

    assign w_wrap      = (r_cnt == I2S_CNT_LAST);
    assign w_bclk_fall = (r_cnt[I2S_BCLK_BIT:0] == '1);
    // Slot index that cnt will hold after this BCLK falling edge.
    assign w_slot      = r_cnt[I2S_SLOT_MSB:I2S_SLOT_LSB] + {{(I2S_SLOT_W-1){1'b0}}, 1'b1};
    assign w_data_slot = slot_has_data(w_slot, BITSIZE);

    assign ready    = r_rdy_en && !w_full;
    assign w_push   = valid && ready;
    assign MCLK     = r_cnt[I2S_BCLK_BIT];
    assign BCLK     = r_cnt[I2S_BCLK_BIT];
    assign DACLRC   = r_cnt[I2S_LR_BIT];
    assign DACDAT   = r_dacdat;
    assign underrun = r_underrun;

    i2s_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (OSC),
        .i_rst_n (RESET),
        .i_push  (w_push),
        .i_wdata ({left_chan, right_chan}),
        .i_pop   (w_wrap),
        .o_rdata (w_fifo_q),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Left word sits in the upper half, so shifting only on data slots walks
    // through left MSB..LSB and then right MSB..LSB.
    always_ff @(posedge OSC or negedge RESET) begin
        if (!RESET) begin
            r_cnt      <= '0;
            r_rdy_en   <= 1'b0;
            r_shreg    <= '0;
            r_dacdat   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_cnt      <= r_cnt + {{(I2S_CNT_W-1){1'b0}}, 1'b1};
            r_rdy_en   <= 1'b1;
            r_underrun <= w_wrap && w_empty;
            if (w_bclk_fall)
                r_dacdat <= w_data_slot ? r_shreg[FW-1] : 1'b0;
            if (w_wrap)
                r_shreg <= w_empty ? '0 : w_fifo_q;
            else if (w_bclk_fall && w_data_slot)
                r_shreg <= {r_shreg[FW-2:0], 1'b0};
        end
    end

`ifdef I2S_UNDERRUN_CNT_EN
    logic [15:0] r_ur_cnt;

    always_ff @(posedge OSC or negedge RESET) begin
        if (!RESET)
            r_ur_cnt <= '0;
        else if (w_wrap && w_empty && (r_ur_cnt != 16'hFFFF))
            r_ur_cnt <= r_ur_cnt + 16'd1;
    end

    assign underrun_count = r_ur_cnt;
`endif
endmodule

// File: doc/i2s_master_tx.md
I2S_MASTER_TX -- requirements
Module: i2s_master_tx

Interface
REQ-001 SHALL have parameter BITSIZE, default 16: audio sample width per channel, legal range 8..31.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: stereo-frame buffer depth, power of two, minimum 2.
REQ-003 SHALL have port OSC  input  1  system clock (49.152 MHz); the only clock.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port left_chan  input  BITSIZE  left sample, two's complement.
REQ-006 SHALL have port right_chan  input  BITSIZE  right sample, two's complement.
REQ-007 SHALL have port valid  input  1  frame on left_chan/right_chan offered.
REQ-008 SHALL have port ready  output  1  block accepts a frame this cycle.
REQ-009 SHALL have port MCLK  output  1  codec master clock, OSC/4.
REQ-010 SHALL have port BCLK  output  1  bit clock, OSC/4.
REQ-011 SHALL have port DACLRC  output  1  word select: low = left, high = right.
REQ-012 SHALL have port DACDAT  output  1  serial data, MSB first.
REQ-013 SHALL have port underrun  output  1  one-OSC-cycle pulse when a frame slot finds the FIFO empty.

Function
REQ-014 SHALL keep an 8-bit free-running counter cnt on OSC; MCLK = BCLK = cnt[1], DACLRC = cnt[7]. Frame = 256 OSC = 64 BCLK; 192 kHz frame rate.
REQ-015 SHALL accept a frame on any OSC edge with valid && ready; ready = FIFO not full. Acceptance is independent of cnt.
REQ-016 SHALL pop one frame from the FIFO into a 2*BITSIZE shift register on the edge where cnt transitions 255->0. An empty FIFO loads all zeros and pulses underrun on that same edge.
REQ-017 SHALL update DACDAT only on edges where cnt[1:0] transitions 3->0, which are BCLK falling edges. Slot k = cnt[6:2] carries 0 for k=0, bit BITSIZE-k for k=1..BITSIZE, and 0 for k>BITSIZE. This gives the I2S one-BCLK delay after the DACLRC transition.
REQ-018 SHALL transmit left during cnt[7]=0 and right during cnt[7]=1.
REQ-019 SHALL allow a push and a pop on the same edge when the FIFO is full. The pop frees a slot, but ready was already low, so no push occurs. When the FIFO is empty, a same-edge push is not visible to the pop, and underrun fires.
REQ-020 SHALL wrap FIFO pointers modulo FIFO_DEPTH and use an extra occupancy bit to tell full from empty.
REQ-021 SHALL give latency from acceptance into an empty FIFO to the MSB on DACDAT as follows: the next 255->0 wrap, plus 4 OSC cycles.

Reset
REQ-022 SHALL, while RESET=0, force cnt=0, the FIFO to empty, the shift register to 0, DACDAT=0, underrun=0 and ready=0.
REQ-023 SHALL assert ready on the first OSC edge after RESET deasserts. The first frame transmitted after reset is silent (zeros) and does not pulse underrun.
REQ-024 SHALL treat reset mid-frame as abandoning the frame. No partial word is resumed after reset.

Configuration
REQ-025 SHALL, with macro I2S_UNDERRUN_CNT_EN defined, add output underrun_count (16 bits). It increments on each underrun pulse, saturates at 0xFFFF and resets to 0.
REQ-026 SHALL, without I2S_UNDERRUN_CNT_EN, omit the underrun_count port and its logic. All other behaviour is identical.

Structure
REQ-027 SHALL place the BITSIZE default, the frame-counter width (8) and the slot-index constants in shared package i2s_pkg, which is also used by i2s_rx and i2s_tx.
REQ-028 SHALL implement the frame buffer as sub-module i2s_frame_fifo, with width 2*BITSIZE, depth FIFO_DEPTH, and a push/pop/full/empty interface.

Verification
REQ-029 SHALL verify reset: with RESET held low for 10 OSC cycles, DACDAT=0, BCLK=0, DACLRC=0 and ready=0; after release, BCLK has period 4 OSC and DACLRC has period 256 OSC.
REQ-030 SHALL verify single frame: push left=16'hA5C3, right=16'h8001 -> DACDAT serialises 1010010111000011 in left slots 1..16 and 1000000000000001 in right slots 1..16, with zeros in all other slots.
REQ-031 SHALL verify back-pressure: hold valid=1 with no frame slots elapsing -> exactly 4 frames accepted and ready=0 after the 4th; ready returns to 1 one OSC cycle after the next pop.
REQ-032 SHALL verify underrun: with the FIFO empty at a 255->0 wrap -> underrun pulses 1 cycle, both channels transmit 0, and (with I2S_UNDERRUN_CNT_EN) underrun_count goes 0->1.
REQ-033 SHALL verify same-edge full push/pop: with the FIFO full and valid=1 at a wrap -> no push that edge, a push on the next edge, and frame order preserved.
REQ-034 SHALL verify mid-frame reset: assert RESET at cnt=100 during frame 0x7FFF/0x7FFF -> DACDAT=0 immediately, and after release the transmitted data is zeros, not the old frame.
